// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode and timing constants for the SPI/FIFO bridge
// No ports: package of localparams imported by the bridge and its bench.
package spi_pkg;
  // SPI mode 0: sck idles low, data sampled on the leading (rising) edge.
  localparam logic MODE_CPOL = 1'b0;
  localparam logic MODE_CPHA = 1'b0;

  // Flops in each clock-domain-crossing synchroniser chain.
  localparam int SYNC_STAGES = 2;

  // Minimum clk cycles per sck period the bridge is built to follow.
  localparam int SCK_RATIO_MIN = 8;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read port
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   push, push_data     write request and word; ignored when full unless a pop
//                       is accepted in the same cycle
//   pop, pop_data       read request; the head word appears on pop_data the
//                       cycle after an accepted pop; pop while empty is ignored
//   full, empty, count  occupancy, from the pointer registers only
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_pop;
  logic              do_push;

  // The extra pointer bit tells a full ring from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_pop  = pop && !empty;
  // A pop frees the head slot this cycle, so a push on a full FIFO can land.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/spi_fifo_bridge.sv
// rtl/spi_fifo_bridge.sv - SPI mode-0 slave bridged to RX and TX word FIFOs
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   ss, sck, mosi, miso      SPI slave pins; inputs asynchronous to clk
//   rx_rd, rx_data, rx_valid pop RX FIFO; word returned with a one-cycle pulse
//   tx_wr, tx_data           push a word to be shifted out on miso
//   rx_count, rx_empty, rx_full, tx_empty, tx_full   FIFO status
//   rx_overflow, tx_underrun sticky error flags, cleared by clr_err
module spi_fifo_bridge
  import spi_pkg::*;
#(
  parameter int               DATA_W = 8,
  parameter int               DEPTH  = 16,
  parameter logic [DATA_W-1:0] FILL  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ss,
  input  logic                   sck,
  input  logic                   mosi,
  output logic                   miso,
  input  logic                   rx_rd,
  output logic [DATA_W-1:0]      rx_data,
  output logic                   rx_valid,
  input  logic                   tx_wr,
  input  logic [DATA_W-1:0]      tx_data,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   rx_empty,
  output logic                   rx_full,
  output logic                   tx_empty,
  output logic                   tx_full,
  output logic                   rx_overflow,
  output logic                   tx_underrun,
  input  logic                   clr_err
);
  localparam int              CW       = $clog2(DATA_W);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
  logic ss_s, sck_lvl, mosi_s;
  logic ss_d, sck_d;
  logic ss_fall, ss_rise, sck_rise, sck_fall, sample_edge, drive_edge;

  logic              active;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic              rx_push_q;
  logic              tx_load, tx_load_q, tx_fill_q;
  logic              rx_pop;
  logic [DATA_W-1:0] tx_head;
  logic [$clog2(DEPTH):0] tx_count_unused;

  // Chains reset low so that ss already low when reset releases never
  // looks like a falling edge; a transfer only starts on a real ss fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync   <= '0;
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_d      <= 1'b0;
      sck_d     <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_d      <= ss_s;
      sck_d     <= sck_lvl;
    end
  end

  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign sck_lvl  = sck_sync[SYNC_STAGES-1] ^ MODE_CPOL;
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ss_fall  = ss_d & ~ss_s;
  assign ss_rise  = ~ss_d & ss_s;
  assign sck_rise = sck_lvl & ~sck_d;
  assign sck_fall = ~sck_lvl & sck_d;
  assign sample_edge = MODE_CPHA ? sck_fall : sck_rise;
  assign drive_edge  = MODE_CPHA ? sck_rise : sck_fall;

  // A new TX word is needed at select and whenever a word boundary passes.
  assign tx_load = ss_fall | (active & sample_edge & (bit_cnt == LAST_BIT));
  assign rx_pop  = rx_rd & ~rx_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rx_push_q <= 1'b0;
      tx_load_q <= 1'b0;
      tx_fill_q <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      tx_load_q <= tx_load;
      tx_fill_q <= tx_load & tx_empty;
      if (ss_fall) begin
        active  <= 1'b1;
        bit_cnt <= '0;
      end else if (ss_rise) begin
        active  <= 1'b0;
        bit_cnt <= '0;
        rx_sh   <= '0;
      end else if (active && sample_edge) begin
        rx_sh     <= {rx_sh[DATA_W-2:0], mosi_s};
        bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        rx_push_q <= (bit_cnt == LAST_BIT);
      end
      // The FIFO read is registered, so the popped head lands a cycle after
      // the load request; sck is slow enough that no drive edge intervenes.
      if (tx_load_q) begin
        tx_sh <= tx_fill_q ? FILL : tx_head;
      end else if (active && drive_edge && (bit_cnt != '0)) begin
        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign miso = active & ~ss_s & tx_sh[DATA_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid    <= 1'b0;
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid <= rx_pop;
      if (rx_push_q && rx_full && !rx_pop) begin
        rx_overflow <= 1'b1;
      end else if (clr_err) begin
        rx_overflow <= 1'b0;
      end
      if (tx_load && tx_empty) begin
        tx_underrun <= 1'b1;
      end else if (clr_err) begin
        tx_underrun <= 1'b0;
      end
    end
  end

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push_q),
    .push_data (rx_sh),
    .pop       (rx_pop),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_wr),
    .push_data (tx_data),
    .pop       (tx_load),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count_unused)
  );
endmodule

// File: doc/spi_fifo_bridge.md
SPI_FIFO_BRIDGE -- requirements
Module: spi_fifo_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 8: SPI word width and FIFO word width, valid range 4..32.
REQ-002 SHALL have parameter DEPTH, default 16: entries per FIFO, power of two, valid range 2..256.
REQ-003 SHALL have parameter FILL, default 0: word shifted out on MISO when the TX FIFO is empty.
REQ-004 SHALL have ports: clk in 1 system clock; rst in 1 reset, synchronous, active-high.
REQ-005 SHALL have ports: ss in 1 SPI select, active-low, asynchronous to clk; sck in 1 SPI clock, async; mosi in 1 async; miso out 1.
REQ-006 SHALL have ports: rx_rd in 1 pop RX; rx_data out DATA_W popped word; rx_valid out 1 rx_data valid pulse.
REQ-007 SHALL have ports: tx_wr in 1 push TX; tx_data in DATA_W word to push.
REQ-008 SHALL have ports: rx_count out $clog2(DEPTH)+1; rx_empty, rx_full, tx_empty, tx_full out 1 each.
REQ-009 SHALL have ports: rx_overflow out 1 sticky; tx_underrun out 1 sticky; clr_err in 1 clears both.

Function
REQ-010 SHALL operate in SPI mode 0, MSB first; sck frequency no more than clk/8.
REQ-011 SHALL pass ss, sck and mosi through two-flop synchronisers, then detect edges on the synchronised ss and sck.
REQ-012 SHALL sample synchronised mosi into the RX shift register on each sck rising edge while ss is low, and increment bit_cnt modulo DATA_W.
REQ-013 SHALL push the RX shift word into the RX FIFO on the clk cycle after the rising edge that completes DATA_W bits.
REQ-014 SHALL, on an RX push while rx_full with no same-cycle pop, drop the word and set rx_overflow; the FIFO contents stay unchanged.
REQ-015 SHALL accept an RX push and pop in the same cycle when full; the count stays unchanged and rx_overflow is not set.
REQ-016 SHALL, when rx_rd is high and rx_empty is low, present the head word on rx_data with rx_valid high exactly one cycle later.
REQ-017 SHALL ignore rx_rd while rx_empty is high; rx_valid stays low.
REQ-018 SHALL push tx_data when tx_wr is high and tx_full is low; tx_wr while tx_full is dropped silently.
REQ-019 SHALL load the TX shift register on the synchronised ss falling edge and on each word completion; on each load it pops the TX FIFO head, or loads FILL and sets tx_underrun if tx_empty.
REQ-020 SHALL drive miso from the TX shift-register MSB while ss is low, and drive 0 while ss is high.
REQ-021 SHALL shift the TX register left on each sck falling edge, except the first falling edge after a load (bit_cnt==0).
REQ-022 SHALL, on ss deassertion mid-word, discard the partial RX word, clear bit_cnt, and not return the already-popped TX word.
REQ-023 SHALL treat a simultaneous TX push and TX load pop with tx_empty as an underrun; the pushed word is stored for the next load.
REQ-024 SHALL wrap FIFO pointers modulo DEPTH, with full/empty derived from an extra pointer bit.
REQ-025 SHALL have clr_err clear the sticky flags; a same-cycle set event wins over clr_err.
REQ-026 SHALL derive rx_count, rx_empty, rx_full, tx_empty and tx_full from registered state only, with no combinational path from inputs.

Reset
REQ-027 SHALL, on rst high at a clk edge, empty both FIFOs and set outputs to: rx_count=0, rx_empty=1, tx_empty=1, rx_full=0, tx_full=0.
REQ-028 SHALL, on reset, set rx_valid=0, rx_data=0, rx_overflow=0, tx_underrun=0 and miso=0, and clear bit_cnt and both shift registers.
REQ-029 SHALL, on reset asserted mid-transfer, abort the transfer; after reset releases, bytes resume only from the next ss falling edge.

Structure
REQ-030 SHALL instantiate one sub-module, sync_fifo (parameters DATA_W, DEPTH; push/pop/full/empty/count/registered read), twice: once for RX and once for TX.
REQ-031 SHALL place the mode-0 constants, the synchroniser stage count (2) and the clk/sck ratio limit (8) in the shared package spi_pkg.

Verification
REQ-032 SHALL cover: reset, preload tx 0xA5, master sends 0x3C -> miso shifts 10100101, rx_count=1, rx_rd then rx_data=0x3C, rx_valid one cycle later.
REQ-033 SHALL cover: DEPTH=4, master sends 5 words, no reads -> rx_full=1, 5th word dropped, rx_overflow=1, reads return words 1..4 in order.
REQ-034 SHALL cover: TX empty, FILL=0xFF, master clocks one word -> miso=0xFF, tx_underrun=1; clr_err -> tx_underrun=0.
REQ-035 SHALL cover: ss raised after 5 bits of 0x81, then full word 0x42 -> RX FIFO holds only 0x42, rx_count=1.
REQ-036 SHALL cover: rx_full with rx_rd and word completion in the same cycle -> rx_count stays DEPTH, rx_overflow=0, newest word read last.
REQ-037 SHALL cover: rst pulsed mid-word with 2 words queued in each FIFO -> all flags at reset values, miso=0, next clean transfer correct.
